// File: rtl/final_project_pio_pkg.sv
// Shared register map and readback layout for the output PIO bank.
package final_project_pio_pkg;

    localparam int unsigned BUS_W         = 32;
    localparam int unsigned PULSE_DUR_LSB = 16;

    typedef enum logic [1:0] {
        REG_DATA  = 2'd0,
        REG_SET   = 2'd1,
        REG_CLR   = 2'd2,
        REG_PULSE = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] mask;
    } pulse_rd_t;

endpackage

// File: rtl/final_project_pio_channel.sv
// One output channel: DATA register with SET/CLR aliases and a self-timed XOR pulse.
module final_project_pio_channel
    import final_project_pio_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     PULSE_W   = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  reg_sel_e           reg_sel,
    input  logic [WIDTH-1:0]   wr_bits,
    input  logic [PULSE_W-1:0] wr_dur,
    output logic [WIDTH-1:0]   data,
    output logic [WIDTH-1:0]   mask,
    output logic [PULSE_W-1:0] cnt,
    output logic [WIDTH-1:0]   out_word_c,
    output logic               pulse_active_c
);

    logic wr_pulse;

    assign wr_pulse       = wr_en && (reg_sel == REG_PULSE);
    assign pulse_active_c = (cnt != '0);
    assign out_word_c     = data ^ (pulse_active_c ? mask : '0);

    // A PULSE write always wins over the countdown, so it restarts or cancels cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= RESET_VAL;
            mask <= '0;
            cnt  <= '0;
        end else begin
            if (wr_en) begin
                case (reg_sel)
                    REG_DATA: data <= wr_bits;
                    REG_SET:  data <= data | wr_bits;
                    REG_CLR:  data <= data & ~wr_bits;
                    default:  ;
                endcase
            end
            if (wr_pulse) begin
                mask <= (wr_dur != '0) ? wr_bits : '0;
                cnt  <= wr_dur;
            end else if (pulse_active_c) begin
                cnt <= cnt - PULSE_W'(1);
                if (cnt == PULSE_W'(1)) begin
                    mask <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/final_project_pio_out_bank.sv
// Avalon-MM output PIO bank: address decode, per-channel write enables and readback mux.
module final_project_pio_out_bank
    import final_project_pio_pkg::*;
#(
    parameter int unsigned      NUM_CH    = 4,
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      PULSE_W   = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned     ADDR_W    = $clog2(NUM_CH) + 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [BUS_W-1:0]        writedata,
    output logic [BUS_W-1:0]        readdata,
    output logic [NUM_CH*WIDTH-1:0] out_port,
    output logic [NUM_CH-1:0]       pulse_active
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0]    ch;
    logic               wr;
    reg_sel_e           reg_sel;
    logic [WIDTH-1:0]   wr_bits;
    logic [PULSE_W-1:0] wr_dur;
    logic               unused_wd;

    logic [WIDTH-1:0]   ch_data [NUM_CH];
    logic [WIDTH-1:0]   ch_mask [NUM_CH];
    logic [PULSE_W-1:0] ch_cnt  [NUM_CH];
    logic [WIDTH-1:0]   ch_out  [NUM_CH];
    logic [BUS_W-1:0]   ch_rd   [NUM_CH];

    if (ADDR_W > 2) begin : g_ch_field
        assign ch = address[ADDR_W-1:2];
    end else begin : g_ch_single
        assign ch = '0;
    end

    assign wr        = chipselect & ~write_n;
    assign reg_sel   = reg_sel_e'(address[1:0]);
    assign wr_bits   = writedata[WIDTH-1:0];
    assign wr_dur    = writedata[PULSE_DUR_LSB +: PULSE_W];
    assign unused_wd = &{1'b0, writedata};

    // Channel indices that decode to no instance get no write enable and read as zero.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        pulse_rd_t pulse_rd;

        final_project_pio_channel #(
            .WIDTH     (WIDTH),
            .PULSE_W   (PULSE_W),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .wr_en          (wr && (ch == CH_W'(c))),
            .reg_sel        (reg_sel),
            .wr_bits        (wr_bits),
            .wr_dur         (wr_dur),
            .data           (ch_data[c]),
            .mask           (ch_mask[c]),
            .cnt            (ch_cnt[c]),
            .out_word_c     (ch_out[c]),
            .pulse_active_c (pulse_active[c])
        );

        assign pulse_rd.cnt                 = 16'(ch_cnt[c]);
        assign pulse_rd.mask                = 16'(ch_mask[c]);
        assign ch_rd[c]                     = (reg_sel == REG_PULSE) ? pulse_rd : BUS_W'(ch_data[c]);
        assign out_port[c*WIDTH +: WIDTH]   = ch_out[c];
    end

    always_comb begin
        readdata = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch == CH_W'(c)) begin
                readdata = ch_rd[c];
            end
        end
    end

endmodule

// File: tb/tb_final_project_pio_out_bank.sv
// Directed scoreboard bench for the output PIO bank (4-channel and 3-channel instances).
module tb_final_project_pio_out_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        cs3;
    logic        write_n;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] readdata3;
    logic [31:0] out_port;
    logic [23:0] out3;
    logic [3:0]  pact;
    logic [2:0]  pact3;

    always #10 clk = ~clk;

    final_project_pio_out_bank #(
        .NUM_CH(4), .WIDTH(8), .PULSE_W(16), .RESET_VAL(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .pulse_active(pact)
    );

    final_project_pio_out_bank #(
        .NUM_CH(3), .WIDTH(8), .PULSE_W(16), .RESET_VAL(8'hA5)
    ) dut3 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs3),
        .write_n(write_n), .writedata(writedata), .readdata(readdata3),
        .out_port(out3), .pulse_active(pact3)
    );

    typedef enum {K_OUT, K_PACT, K_RD, K_OUT3, K_RD3} kind_e;
    typedef struct {
        kind_e       kind;
        logic [3:0]  addr;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    function automatic logic [3:0] a(int ch, int r);
        return 4'((ch << 2) | r);
    endfunction

    task automatic push(kind_e k, logic [3:0] ad, logic [31:0] e, string t);
        exp_t x;
        x.kind = k;
        x.addr = ad;
        x.exp  = e;
        x.tag  = t;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t        x;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            x   = sb.pop_front();
            obs = '0;
            case (x.kind)
                K_OUT:  obs = out_port;
                K_PACT: obs = 32'(pact);
                K_OUT3: obs = 32'(out3);
                K_RD, K_RD3: begin
                    address = x.addr;
                    #1;
                    obs = (x.kind == K_RD) ? readdata : readdata3;
                end
                default: obs = 'x;
            endcase
            checks++;
            assert (obs === x.exp) else begin
                fails++;
                $error("FAIL %s: got %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic wr(bit to3, logic [3:0] ad, logic [31:0] d);
        address   = ad;
        writedata = d;
        write_n   = 1'b0;
        if (to3) cs3 = 1'b1;
        else     cs  = 1'b1;
        @(posedge clk);
        #1;
        write_n = 1'b1;
        cs      = 1'b0;
        cs3     = 1'b0;
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        cs        = 1'b0;
        cs3       = 1'b0;
        write_n   = 1'b1;
        address   = '0;
        writedata = '0;
        tick(2);
        reset = 1'b0;

        // reset state
        push(K_OUT,  '0,      32'hA5A5A5A5, "rst_out");
        push(K_PACT, '0,      32'h0,        "rst_pact");
        push(K_RD,   a(0, 0), 32'h000000A5, "rst_rd_data0");
        push(K_RD,   a(2, 1), 32'h000000A5, "rst_rd_set2");
        push(K_RD,   a(3, 3), 32'h0,        "rst_rd_pulse3");
        push(K_OUT3, '0,      32'h00A5A5A5, "rst_out3");
        drain();

        // DATA / SET / CLR on ch1
        wr(0, a(1, 0), 32'h0000000F);
        wr(0, a(1, 1), 32'h000000F0);
        push(K_OUT, '0, 32'hA5A5FFA5, "set_out");
        drain();
        wr(0, a(1, 2), 32'h0000003C);
        push(K_OUT, '0,      32'hA5A5C3A5, "clr_out");
        push(K_RD,  a(1, 0), 32'h000000C3, "clr_rd");
        drain();

        // upper writedata bits ignored
        wr(0, a(2, 0), 32'hFFFFFF5A);
        push(K_RD,  a(2, 0), 32'h0000005A, "wide_wd_rd");
        push(K_OUT, '0,      32'hA55AC3A5, "wide_wd_out");
        drain();

        // read during a write to the same register returns the old value
        address   = a(2, 0);
        writedata = 32'h00000033;
        write_n   = 1'b0;
        cs        = 1'b1;
        push(K_RD, a(2, 0), 32'h0000005A, "rd_during_wr");
        drain();
        @(posedge clk);
        #1;
        write_n = 1'b1;
        cs      = 1'b0;
        push(K_RD, a(2, 0), 32'h00000033, "rd_after_wr");
        drain();

        // 5-cycle pulse on ch0
        wr(0, a(0, 0), 32'h00000000);
        wr(0, a(0, 3), {16'd5, 16'h0081});
        for (int k = 0; k < 5; k++) begin
            push(K_OUT,  '0,      32'hA533C381,             $sformatf("pulse_out_%0d", k));
            push(K_PACT, '0,      32'h1,                    $sformatf("pulse_pact_%0d", k));
            push(K_RD,   a(0, 3), {16'(5 - k), 16'h0081}, $sformatf("pulse_cnt_%0d", k));
            drain();
            tick(1);
        end
        push(K_OUT,  '0,      32'hA533C300, "pulse_end_out");
        push(K_PACT, '0,      32'h0,        "pulse_end_pact");
        push(K_RD,   a(0, 3), 32'h0,        "pulse_end_cnt");
        drain();

        // restart mid-pulse, DATA write during pulse, then cancel
        wr(0, a(0, 3), {16'd6, 16'h0081});
        tick(3);
        push(K_RD, a(0, 3), 32'h00030081, "restart_pre");
        drain();
        wr(0, a(0, 3), {16'd10, 16'h0001});
        push(K_RD,  a(0, 3), 32'h000A0001, "restart_cnt");
        push(K_OUT, '0,      32'hA533C301, "restart_out");
        drain();
        tick(1);
        push(K_RD, a(0, 3), 32'h00090001, "restart_dec");
        drain();
        wr(0, a(0, 0), 32'h00000010);
        push(K_OUT,  '0,      32'hA533C311, "data_in_pulse_out");
        push(K_RD,   a(0, 0), 32'h00000010, "data_in_pulse_rd");
        push(K_PACT, '0,      32'h1,        "data_in_pulse_pact");
        drain();
        wr(0, a(0, 3), 32'h000000FF);
        push(K_OUT,  '0,      32'hA533C310, "cancel_out");
        push(K_PACT, '0,      32'h0,        "cancel_pact");
        push(K_RD,   a(0, 3), 32'h0,        "cancel_rd");
        drain();

        // reset mid-pulse on ch3
        wr(0, a(3, 3), {16'd4, 16'h00FF});
        tick(2);
        push(K_OUT,  '0,      32'h5A33C310, "pre_rst_out");
        push(K_RD,   a(3, 3), 32'h000200FF, "pre_rst_cnt");
        push(K_PACT, '0,      32'h8,        "pre_rst_pact");
        drain();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        push(K_OUT,  '0,      32'hA5A5A5A5, "mid_rst_out");
        push(K_PACT, '0,      32'h0,        "mid_rst_pact");
        push(K_RD,   a(3, 3), 32'h0,        "mid_rst_cnt");
        drain();

        // out-of-range channel on the 3-channel bank
        wr(1, a(3, 0), 32'h00000012);
        wr(1, a(3, 3), 32'h00050001);
        push(K_OUT3, '0,      32'h00A5A5A5, "oor_out3");
        push(K_RD3,  a(3, 0), 32'h0,        "oor_rd3_data");
        push(K_RD3,  a(3, 3), 32'h0,        "oor_rd3_pulse");
        push(K_OUT,  '0,      32'hA5A5A5A5, "no_cs_out");
        drain();
        wr(1, a(2, 1), 32'h0000000A);
        push(K_OUT3, '0,      32'h00AFA5A5, "inrange_out3");
        push(K_RD3,  a(2, 0), 32'h000000AF, "inrange_rd3");
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
